// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and helpers for the frame arbiter
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Index width for n items, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin picker over a doubled request vector
module rr_select
  import axis_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IDX_W = clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*PORTS-1:0] dbl;
  logic [IDX_W:0]     pos;

  assign dbl = {req, req};
  assign any = |req;

  // Walk from farthest to nearest so the first hit after last wins.
  always_comb begin
    idx = '0;
    pos = '0;
    for (int k = PORTS; k >= 1; k--) begin
      pos = {1'b0, last} + (IDX_W+1)'(k);
      if (int'(pos) < 2*PORTS && dbl[pos]) begin
        if (int'(pos) >= PORTS) idx = IDX_W'(int'(pos) - PORTS);
        else                    idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin arbiter onto one registered AXI-stream output
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        grant_valid,
  output logic [clog2(PORTS)-1:0]     grant_index
);

  localparam int IDX_W = clog2(PORTS);

  arb_state_t            state, state_next;
  logic [IDX_W-1:0]      last_grant;
  logic                  req_any;
  logic [IDX_W-1:0]      pick;
  logic                  can_load;
  logic                  accept;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_select #(
    .PORTS(PORTS),
    .IDX_W(IDX_W)
  ) u_rr_select (
    .req  (input_axis_tvalid),
    .last (last_grant),
    .any  (req_any),
    .idx  (pick)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_index == IDX_W'(i)) begin
        sel_valid = input_axis_tvalid[i];
        sel_last  = input_axis_tlast[i];
        sel_data  = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign can_load    = output_axis_tready | ~output_axis_tvalid;
  assign accept      = (state == XFER) & can_load & sel_valid;
  assign grant_valid = (state == XFER);

  always_comb begin
    input_axis_tready = '0;
    if (state == XFER) begin
      for (int i = 0; i < PORTS; i++) begin
        input_axis_tready[i] = (grant_index == IDX_W'(i)) & can_load;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_any) state_next = XFER;
      XFER:    if (accept && sel_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // last_grant starts at PORTS-1 so the first search begins at port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_index <= '0;
      last_grant  <= IDX_W'(PORTS - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && req_any) begin
        grant_index <= pick;
        last_grant  <= pick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_axis_tvalid <= 1'b0;
      output_axis_tdata  <= '0;
      output_axis_tlast  <= 1'b0;
    end else if (accept) begin
      output_axis_tvalid <= 1'b1;
      output_axis_tdata  <= sel_data;
      output_axis_tlast  <= sel_last;
    end else if (can_load) begin
      output_axis_tvalid <= 1'b0;
    end
  end

endmodule
